// File: rtl/mak_bus_pkg.sv
// rtl/mak_bus_pkg.sv - shared types and master indices for the memory bus arbiter
package mak_bus_pkg;

    // Arbiter FSM: IDLE between grants, GRANT while a master owns the port
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Fixed master slots on the shared data-memory port
    localparam int MST_CORE0 = 0;
    localparam int MST_CORE1 = 1;
    localparam int MST_DMA   = 2;

    // Width of a master index for a given master count
    function automatic int idx_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority request picker
module rr_picker #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_id_i,
    output logic [IDX_W-1:0]       next_id_o,
    output logic                   any_req_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan last_id+1, last_id+2, ... wrapping, so the previous owner is checked last
    always_comb begin
        next_id_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IDX_W'((int'(last_id_i) + i) % NUM_MASTERS);
            if (!found && req_i[idx]) begin
                next_id_o = idx;
                found     = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin owner-held arbiter for the data-memory port (option: ARB_TIMEOUT_EN)
module mem_bus_arbiter
    import mak_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_HOLD    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0]              m_req,
    input  logic [NUM_MASTERS-1:0]              m_we,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
    output logic [DATA_W-1:0]                   m_rdata,
    output logic [NUM_MASTERS-1:0]              m_ready,
    output logic                                s_req,
    output logic                                s_we,
    output logic [ADDR_W-1:0]                   s_addr,
    output logic [DATA_W-1:0]                   s_wdata,
    input  logic [DATA_W-1:0]                   s_rdata,
    input  logic                                s_ready,
    output logic [2:0]                          grant_id,
    output logic                                busy
);

    localparam int IDX_W = idx_width(NUM_MASTERS);

    // Elaboration-time parameter sanity
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
        $error("mem_bus_arbiter: NUM_MASTERS must be 2..8");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("mem_bus_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_t             state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       pick_id;
    logic                   any_req;
    logic                   owner_req;
    logic [NUM_MASTERS-1:0] owner_oh;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] beat_cnt_q;
    logic             others_req;
    logic             hold_expired;

    // Someone else is waiting and the owner's final allowed beat is completing now
    assign others_req   = |(m_req & ~owner_oh);
    assign hold_expired = s_ready && owner_req && (beat_cnt_q == HOLD_LAST) && others_req;
`endif

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_picker (
        .req_i       (m_req),
        .last_id_i   (last_q),
        .next_id_o   (pick_id),
        .any_req_o   (any_req)
    );

    assign owner_oh  = NUM_MASTERS'(1) << grant_q;
    assign owner_req = m_req[grant_q];
    assign m_rdata   = s_rdata;
    assign busy      = (state_q == GRANT);
    assign grant_id  = 3'(grant_q);

    // Route the owner's request onto the slave port; nothing reaches the slave outside GRANT
    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        m_ready = '0;
        if (state_q == GRANT) begin
            s_req   = owner_req;
            s_we    = m_we[grant_q];
            s_addr  = m_addr[grant_q];
            s_wdata = m_wdata[grant_q];
            if (s_ready && owner_req) begin
                m_ready = owner_oh;
            end
        end
    end

    // Arbitration FSM: grant on any request, hold while owner keeps req, release through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= pick_id;
                        state_q <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        beat_cnt_q <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        last_q  <= grant_q;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_expired) begin
                        state_q <= IDLE;
                        last_q  <= grant_q;
                    end else if (s_ready && beat_cnt_q != HOLD_MAX) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
